// File: rtl/host_channel_router.sv
// host_channel_router
//   Routes host-to-fabric items from a small input FIFO to one of NUM_CLIENTS
//   request-manager clients, and returns the selected client's responses to
//   the host. In IDLE the head item's command (the whole item word, unsigned)
//   picks the route: [CMD_LO, CMD_HI] goes to client 0 and anything else is
//   dropped and counted. A client raising cl_lock_i takes exclusive ownership
//   (LOCKED) until it drops its own lock bit.
//
//   Configuration macro: HOST_IF_OUT_REG_EN
//     defined   - return path goes through a one-entry output register
//     undefined - return path is a combinational mux
//
//   Ports
//     clk, reset                      clock, async active-high reset
//     item_data_i/item_valid_i        host item in; item_avail_o = can accept
//     item_data_o/item_valid_o        item back to host; item_avail_i = host ready
//     cl_item_data_o/cl_item_valid_o  items to each client; cl_item_avail_i = client ready
//     cl_item_data_i/cl_item_valid_i  client responses; cl_item_avail_o = return ready
//     cl_lock_i                       per-client exclusive-ownership request
//     owner_o, locked_o               selected client, LOCKED state
//     conflict_o                      sticky: more than one lock bit seen at once
//     drop_count_o                    saturating count of dropped items
module host_channel_router #(
  parameter int unsigned ITEM_w        = 32,
  parameter int unsigned NUM_CLIENTS   = 2,
  parameter int unsigned IN_FIFO_DEPTH = 4,
  parameter int unsigned CMD_LO        = 0,
  parameter int unsigned CMD_HI        = 15
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic [ITEM_w-1:0]                       item_data_i,
  input  logic                                    item_valid_i,
  output logic                                    item_avail_o,
  output logic [ITEM_w-1:0]                       item_data_o,
  output logic                                    item_valid_o,
  input  logic                                    item_avail_i,
  output logic [NUM_CLIENTS-1:0][ITEM_w-1:0]      cl_item_data_o,
  output logic [NUM_CLIENTS-1:0]                  cl_item_valid_o,
  input  logic [NUM_CLIENTS-1:0]                  cl_item_avail_i,
  input  logic [NUM_CLIENTS-1:0][ITEM_w-1:0]      cl_item_data_i,
  input  logic [NUM_CLIENTS-1:0]                  cl_item_valid_i,
  output logic [NUM_CLIENTS-1:0]                  cl_item_avail_o,
  input  logic [NUM_CLIENTS-1:0]                  cl_lock_i,
  output logic [$clog2(NUM_CLIENTS)-1:0]          owner_o,
  output logic                                    locked_o,
  output logic                                    conflict_o,
  output logic [15:0]                             drop_count_o
);

  localparam int unsigned OW = $clog2(NUM_CLIENTS);
  localparam int unsigned PW = $clog2(IN_FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [ITEM_w-1:0] CMD_LO_W   = ITEM_w'(CMD_LO);
  localparam logic [ITEM_w-1:0] CMD_SPAN_W = ITEM_w'(CMD_HI - CMD_LO);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t              state_q;
  logic [OW-1:0]       owner_q;
  logic                conflict_q;
  logic [15:0]         drop_q;
  logic                rdy_q;

  logic [ITEM_w-1:0]   mem [IN_FIFO_DEPTH];
  logic [PW-1:0]       wr_ptr_q;
  logic [PW-1:0]       rd_ptr_q;
  logic [CW-1:0]       count_q;

  logic                empty;
  logic                full;
  logic [ITEM_w-1:0]   head;
  logic                any_lock;
  logic                in_range;
  logic                locked;
  logic                route_vld;
  logic                drop;
  logic                push;
  logic                pop;
  logic [OW-1:0]       lock_idx;
  logic                host_avail;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(IN_FIFO_DEPTH));
  assign head     = mem[rd_ptr_q];
  assign any_lock = |cl_lock_i;
  assign locked   = (state_q == ST_LOCKED);
  // Offset compare: one unsigned test covers both bounds without a ">= 0" term.
  assign in_range = ((head - CMD_LO_W) <= CMD_SPAN_W);

  // Head is offered to the owner when locked, otherwise only in-range commands.
  assign route_vld = !empty && (locked || in_range);
  // Drop only in a settled IDLE cycle; a pending lock request defers decode.
  assign drop      = !empty && !locked && !any_lock && !in_range;

  // rdy_q keeps item_avail_o low until the first edge after reset is released.
  assign item_avail_o = rdy_q && !full;
  assign push         = item_valid_i && item_avail_o;
  assign pop          = (route_vld && cl_item_avail_i[owner_q]) || drop;

  assign owner_o      = owner_q;
  assign locked_o     = locked;
  assign conflict_o   = conflict_q;
  assign drop_count_o = drop_q;

  // Lowest-index requester wins ownership.
  always_comb begin
    lock_idx = '0;
    for (int i = int'(NUM_CLIENTS) - 1; i >= 0; i--) begin
      if (cl_lock_i[i]) lock_idx = OW'(i);
    end
  end

  // Forward path: only the selected client sees the head item.
  always_comb begin
    cl_item_valid_o = '0;
    cl_item_data_o  = '0;
    cl_item_valid_o[owner_q] = route_vld;
    cl_item_data_o[owner_q]  = route_vld ? head : '0;
  end

  // Return-path availability goes to the owner only.
  always_comb begin
    cl_item_avail_o = '0;
    cl_item_avail_o[owner_q] = host_avail;
  end

  // FIFO storage (no reset needed; validity is tracked by count_q).
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= item_data_i;
  end

  // FIFO pointers, FSM, ownership, conflict and drop counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rdy_q      <= 1'b0;
      state_q    <= ST_IDLE;
      owner_q    <= '0;
      conflict_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      rdy_q <= 1'b1;

      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase

      if (drop && (drop_q != 16'hFFFF)) drop_q <= drop_q + 16'd1;

      if ($countones(cl_lock_i) > 1) conflict_q <= 1'b1;

      case (state_q)
        ST_IDLE: begin
          if (any_lock) begin
            state_q <= ST_LOCKED;
            owner_q <= lock_idx;
          end
        end
        ST_LOCKED: begin
          // Only the owner's own lock bit matters while locked.
          if (!cl_lock_i[owner_q]) begin
            state_q <= ST_IDLE;
            owner_q <= '0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          owner_q <= '0;
        end
      endcase
    end
  end

`ifdef HOST_IF_OUT_REG_EN
  logic              out_vld_q;
  logic [ITEM_w-1:0] out_data_q;
  logic              ret_take;

  assign host_avail   = rdy_q && (!out_vld_q || item_avail_i);
  assign ret_take     = cl_item_valid_i[owner_q] && host_avail;
  assign item_valid_o = out_vld_q;
  assign item_data_o  = out_data_q;

  // One-entry skid: holds its word until the host takes it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
    end else if (ret_take) begin
      out_vld_q  <= 1'b1;
      out_data_q <= cl_item_data_i[owner_q];
    end else if (item_avail_i) begin
      out_vld_q  <= 1'b0;
    end
  end
`else
  assign host_avail   = rdy_q && item_avail_i;
  assign item_valid_o = rdy_q && cl_item_valid_i[owner_q];
  assign item_data_o  = cl_item_data_i[owner_q];
`endif

endmodule

// File: tb/tb_host_channel_router.sv
module tb_host_channel_router;

  localparam int unsigned W = 32;

  logic              clk;
  logic              reset;
  logic [W-1:0]      item_data_i;
  logic              item_valid_i;
  logic              item_avail_o;
  logic [W-1:0]      item_data_o;
  logic              item_valid_o;
  logic              item_avail_i;
  logic [1:0][W-1:0] cl_item_data_o;
  logic [1:0]        cl_item_valid_o;
  logic [1:0]        cl_item_avail_i;
  logic [1:0][W-1:0] cl_item_data_i;
  logic [1:0]        cl_item_valid_i;
  logic [1:0]        cl_item_avail_o;
  logic [1:0]        cl_lock_i;
  logic              owner_o;
  logic              locked_o;
  logic              conflict_o;
  logic [15:0]       drop_count_o;

  int checks = 0;
  int errors = 0;
  int exp_drop = 0;

  logic [W-1:0] rx0[$];
  logic [W-1:0] rx1[$];
  logic [W-1:0] host_q[$];

  host_channel_router #(
    .ITEM_w(32), .NUM_CLIENTS(2), .IN_FIFO_DEPTH(4), .CMD_LO(0), .CMD_HI(15)
  ) dut (
    .clk(clk), .reset(reset),
    .item_data_i(item_data_i), .item_valid_i(item_valid_i), .item_avail_o(item_avail_o),
    .item_data_o(item_data_o), .item_valid_o(item_valid_o), .item_avail_i(item_avail_i),
    .cl_item_data_o(cl_item_data_o), .cl_item_valid_o(cl_item_valid_o),
    .cl_item_avail_i(cl_item_avail_i),
    .cl_item_data_i(cl_item_data_i), .cl_item_valid_i(cl_item_valid_i),
    .cl_item_avail_o(cl_item_avail_o), .cl_lock_i(cl_lock_i),
    .owner_o(owner_o), .locked_o(locked_o), .conflict_o(conflict_o),
    .drop_count_o(drop_count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record handshakes half a cycle ahead of the edge that completes them.
  always @(negedge clk) begin
    if (!reset) begin
      if (cl_item_valid_o[0] && cl_item_avail_i[0]) rx0.push_back(cl_item_data_o[0]);
      if (cl_item_valid_o[1] && cl_item_avail_i[1]) rx1.push_back(cl_item_data_o[1]);
      if (item_valid_o && item_avail_i) host_q.push_back(item_data_o);
    end
  end

  function automatic bit to_client0(input logic [W-1:0] cmd);
    return (cmd <= 32'd15);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_item(input logic [W-1:0] d, input bit rand_av);
    bit ok;
    int w;
    ok = 1'b0;
    w = 0;
    item_data_i  = d;
    item_valid_i = 1'b1;
    while (!ok && w < 60) begin
      if (rand_av) cl_item_avail_i = 2'($urandom);
      @(negedge clk);
      ok = item_avail_o;
      tick();
      w++;
    end
    item_valid_i = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL push_timeout data=%0h waited=%0d cycles", d, w);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #1 reset = 1'b1;
    #1;
    checks++;
    if ({item_avail_o, item_valid_o, cl_item_valid_o, locked_o, conflict_o, owner_o} !== 7'b0 ||
        drop_count_o !== 16'd0 || cl_item_data_o !== '0) begin
      errors++;
      $display("FAIL reset_outputs avail=%b vld=%b clv=%b lck=%b cf=%b own=%b drop=%0d want all zero",
               item_avail_o, item_valid_o, cl_item_valid_o, locked_o, conflict_o, owner_o, drop_count_o);
    end
    tick(); tick();
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (item_avail_o !== 1'b0) begin
      errors++;
      $display("FAIL avail_before_first_edge got=%b want=0", item_avail_o);
    end
    tick();
    @(negedge clk);
    checks++;
    if (item_avail_o !== 1'b1) begin
      errors++;
      $display("FAIL avail_after_first_edge got=%b want=1", item_avail_o);
    end
    tick();
  endtask

  task automatic test_basic();
    logic [W-1:0] exp_q[$];
    rx0.delete(); rx1.delete();
    cl_item_avail_i = 2'b11;
    push_item(32'd3, 1'b0);
    push_item(32'd5, 1'b0);
    push_item(32'd20, 1'b0);
    exp_q = '{32'd3, 32'd5};
    exp_drop += 1;
    repeat (6) tick();
    @(negedge clk);
    checks++;
    if (rx0 !== exp_q || rx1.size() != 0) begin
      errors++;
      $display("FAIL basic_route rx0_size=%0d rx1_size=%0d want rx0={3,5} rx1={}", rx0.size(), rx1.size());
    end
    checks++;
    if (drop_count_o !== 16'(exp_drop) || owner_o !== 1'b0) begin
      errors++;
      $display("FAIL basic_drop drop=%0d owner=%0d want drop=%0d owner=0", drop_count_o, owner_o, exp_drop);
    end
    tick();
  endtask

  task automatic test_backpressure();
    logic [W-1:0] exp_q[$];
    logic [W-1:0] d;
    rx0.delete();
    cl_item_avail_i = 2'b00;
    for (int i = 0; i < 4; i++) begin
      d = 32'($urandom_range(0, 15));
      exp_q.push_back(d);
      push_item(d, 1'b0);
    end
    @(negedge clk);
    checks++;
    if (item_avail_o !== 1'b0) begin
      errors++;
      $display("FAIL full_avail got=%b want=0", item_avail_o);
    end
    d = 32'($urandom_range(0, 15));
    exp_q.push_back(d);
    tick();
    item_data_i  = d;
    item_valid_i = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    checks++;
    if (item_avail_o !== 1'b0 || rx0.size() != 0) begin
      errors++;
      $display("FAIL full_hold avail=%b rx0_size=%0d want avail=0 size=0", item_avail_o, rx0.size());
    end
    tick();
    cl_item_avail_i = 2'b11;
    push_item(d, 1'b0);
    repeat (8) tick();
    @(negedge clk);
    checks++;
    if (rx0 !== exp_q) begin
      errors++;
      $display("FAIL backpressure_order rx0_size=%0d want=%0d", rx0.size(), exp_q.size());
    end
    tick();
  endtask

  task automatic test_random_route();
    logic [W-1:0] exp_q[$];
    logic [W-1:0] d;
    rx0.delete(); rx1.delete();
    for (int i = 0; i < 30; i++) begin
      d = 32'($urandom_range(0, 31));
      if (to_client0(d)) exp_q.push_back(d);
      else exp_drop++;
      push_item(d, 1'b1);
    end
    cl_item_avail_i = 2'b11;
    repeat (10) tick();
    @(negedge clk);
    checks++;
    if (rx0 !== exp_q || rx1.size() != 0) begin
      errors++;
      $display("FAIL random_route rx0_size=%0d want=%0d rx1_size=%0d", rx0.size(), exp_q.size(), rx1.size());
    end
    checks++;
    if (drop_count_o !== 16'(exp_drop)) begin
      errors++;
      $display("FAIL random_drop got=%0d want=%0d", drop_count_o, exp_drop);
    end
    tick();
  endtask

  task automatic test_lock();
    logic [W-1:0] exp_q[$];
    logic [W-1:0] d;
    rx0.delete(); rx1.delete();
    cl_item_avail_i = 2'b11;
    cl_lock_i = 2'b10;
    tick();
    @(negedge clk);
    checks++;
    if (locked_o !== 1'b1 || owner_o !== 1'b1) begin
      errors++;
      $display("FAIL lock_enter locked=%b owner=%0d want 1/1", locked_o, owner_o);
    end
    tick();
    push_item(32'd40, 1'b0);
    push_item(32'd41, 1'b0);
    exp_q = '{32'd40, 32'd41};
    for (int i = 0; i < 8; i++) begin
      d = $urandom;
      exp_q.push_back(d);
      push_item(d, 1'b1);
    end
    cl_item_avail_i = 2'b11;
    repeat (8) tick();
    @(negedge clk);
    checks++;
    if (rx1 !== exp_q || rx0.size() != 0) begin
      errors++;
      $display("FAIL lock_route rx1_size=%0d want=%0d rx0_size=%0d", rx1.size(), exp_q.size(), rx0.size());
    end
    checks++;
    if (drop_count_o !== 16'(exp_drop)) begin
      errors++;
      $display("FAIL lock_nodrop got=%0d want=%0d", drop_count_o, exp_drop);
    end
    tick();
    cl_lock_i = 2'b00;
    @(negedge clk);
    checks++;
    if (locked_o !== 1'b1) begin
      errors++;
      $display("FAIL lock_hold_before_edge locked=%b want=1", locked_o);
    end
    tick();
    @(negedge clk);
    checks++;
    if (locked_o !== 1'b0 || owner_o !== 1'b0 || conflict_o !== 1'b0) begin
      errors++;
      $display("FAIL lock_exit locked=%b owner=%0d conflict=%b want 0/0/0", locked_o, owner_o, conflict_o);
    end
    tick();
  endtask

  task automatic test_return();
    logic [W-1:0] exp_q[$];
    logic [W-1:0] d;
    bit ok;
    int w;
    item_avail_i = 1'b0;
    cl_lock_i = 2'b10;
    tick();
    host_q.delete();
    cl_item_valid_i = 2'b11;
    cl_item_data_i[1] = 32'hCAFE;
    cl_item_data_i[0] = 32'hBEEF;
    @(negedge clk);
`ifdef HOST_IF_OUT_REG_EN
    checks++;
    if (item_valid_o !== 1'b0 || cl_item_avail_o !== 2'b10) begin
      errors++;
      $display("FAIL ret_send_cycle vld=%b clav=%b want 0/10", item_valid_o, cl_item_avail_o);
    end
    tick();
    cl_item_valid_i[1] = 1'b0;
    @(negedge clk);
`endif
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (item_valid_o !== 1'b1 || item_data_o !== 32'hCAFE || cl_item_avail_o !== 2'b00) begin
        errors++;
        $display("FAIL ret_hold%0d vld=%b data=%h clav=%b want 1/cafe/00", k, item_valid_o, item_data_o, cl_item_avail_o);
      end
      if (k == 0) begin
        tick();
        @(negedge clk);
      end
    end
    tick();
    item_avail_i = 1'b1;
    @(negedge clk);
    checks++;
    if (item_valid_o !== 1'b1 || item_data_o !== 32'hCAFE || cl_item_avail_o !== 2'b10) begin
      errors++;
      $display("FAIL ret_release vld=%b data=%h clav=%b want 1/cafe/10", item_valid_o, item_data_o, cl_item_avail_o);
    end
    tick();
    cl_item_valid_i = 2'b00;
    @(negedge clk);
    checks++;
    if (item_valid_o !== 1'b0 || host_q.size() != 1) begin
      errors++;
      $display("FAIL ret_single vld=%b host_items=%0d want 0/1", item_valid_o, host_q.size());
    end
    tick();
    // Random words from the owner with random host readiness; client 0 chatters.
    host_q.delete();
    for (int i = 0; i < 10; i++) begin
      d = $urandom;
      exp_q.push_back(d);
      cl_item_valid_i = 2'b11;
      cl_item_data_i[1] = d;
      ok = 1'b0;
      w = 0;
      while (!ok && w < 60) begin
        cl_item_data_i[0] = $urandom;
        item_avail_i = 1'($urandom);
        @(negedge clk);
        ok = cl_item_avail_o[1];
        checks++;
        if (cl_item_avail_o[0] !== 1'b0) begin
          errors++;
          $display("FAIL ret_unselected_avail got=%b want=0", cl_item_avail_o[0]);
        end
        tick();
        w++;
      end
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL ret_timeout word=%0d waited=%0d", i, w);
      end
    end
    cl_item_valid_i = 2'b00;
    item_avail_i = 1'b1;
    repeat (4) tick();
    @(negedge clk);
    checks++;
    if (host_q !== exp_q) begin
      errors++;
      $display("FAIL ret_random host_items=%0d want=%0d", host_q.size(), exp_q.size());
    end
    cl_lock_i = 2'b00;
    tick();
    tick();
  endtask

  task automatic test_conflict();
    cl_lock_i = 2'b11;
    tick();
    cl_lock_i = 2'b00;
    @(negedge clk);
    checks++;
    if (owner_o !== 1'b0 || conflict_o !== 1'b1 || locked_o !== 1'b1) begin
      errors++;
      $display("FAIL conflict_set owner=%0d conflict=%b locked=%b want 0/1/1", owner_o, conflict_o, locked_o);
    end
    repeat (3) tick();
    @(negedge clk);
    checks++;
    if (conflict_o !== 1'b1 || locked_o !== 1'b0) begin
      errors++;
      $display("FAIL conflict_sticky conflict=%b locked=%b want 1/0", conflict_o, locked_o);
    end
    tick();
  endtask

  task automatic test_reset_midstream();
    cl_item_avail_i = 2'b00;
    for (int i = 0; i < 3; i++) push_item(32'($urandom_range(0, 15)), 1'b0);
    #2 reset = 1'b1;
    #1;
    exp_drop = 0;
    checks++;
    if ({item_avail_o, item_valid_o, cl_item_valid_o, locked_o, conflict_o, owner_o} !== 7'b0 ||
        drop_count_o !== 16'd0) begin
      errors++;
      $display("FAIL midreset_outputs avail=%b vld=%b clv=%b lck=%b cf=%b own=%b drop=%0d want all zero",
               item_avail_o, item_valid_o, cl_item_valid_o, locked_o, conflict_o, owner_o, drop_count_o);
    end
    tick();
    reset = 1'b0;
    rx0.delete(); rx1.delete();
    cl_item_avail_i = 2'b11;
    repeat (6) tick();
    @(negedge clk);
    checks++;
    if (rx0.size() != 0 || rx1.size() != 0 || item_avail_o !== 1'b1) begin
      errors++;
      $display("FAIL midreset_stale rx0=%0d rx1=%0d avail=%b want 0/0/1", rx0.size(), rx1.size(), item_avail_o);
    end
    tick();
  endtask

  initial begin
    item_data_i     = '0;
    item_valid_i    = 1'b0;
    item_avail_i    = 1'b1;
    cl_item_avail_i = 2'b00;
    cl_item_data_i  = '0;
    cl_item_valid_i = 2'b00;
    cl_lock_i       = 2'b00;
    test_reset();
    test_basic();
    test_backpressure();
    test_random_route();
    test_lock();
    test_return();
    test_conflict();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/host_channel_router.md
HOST_CHANNEL_ROUTER -- requirements
Module: host_channel_router

Interface
REQ-001 Parameter ITEM_w, default 32: width of every item port.
REQ-002 Parameter NUM_CLIENTS, default 2: number of request-manager clients, at least 2.
REQ-003 Parameter IN_FIFO_DEPTH, default 4: input FIFO entries, a power of 2 and at least 2.
REQ-004 Parameters CMD_LO, default 0, and CMD_HI, default 15: command range routed to client 0 when the router is unlocked.
REQ-005 clk  in  1  single clock; all state changes on the rising edge.
REQ-006 reset  in  1  reset; asynchronous and active-high.
REQ-007 item_data_i / item_valid_i  in  ITEM_w / 1  host-to-fabric item and its valid.
REQ-008 item_avail_o  out  1  router can accept a host item this cycle.
REQ-009 item_data_o / item_valid_o  out  ITEM_w / 1  fabric-to-host item and its valid.
REQ-010 item_avail_i  in  1  host can accept an item.
REQ-011 cl_item_data_o / cl_item_valid_o  out  NUM_CLIENTS x ITEM_w / NUM_CLIENTS  items to each client, with valid.
REQ-012 cl_item_avail_i  in  NUM_CLIENTS  client can accept an item.
REQ-013 cl_item_data_i / cl_item_valid_i  in  NUM_CLIENTS x ITEM_w / NUM_CLIENTS  client responses, with valid.
REQ-014 cl_item_avail_o  out  NUM_CLIENTS  host-path availability returned to each client.
REQ-015 cl_lock_i  in  NUM_CLIENTS  client requests exclusive ownership of the channel.
REQ-016 owner_o  out  $clog2(NUM_CLIENTS)  current selected client.
REQ-017 locked_o  out  1  router is in the LOCKED state.
REQ-018 conflict_o  out  1  sticky flag: concurrent lock requests were seen.
REQ-019 drop_count_o  out  16  count of unroutable items dropped.

Function
REQ-020 Input FIFO behaviour:
- a write occurs when item_valid_i and item_avail_o are both high;
- item_avail_o = !full, so no write is accepted when full, even on a same-cycle pop.
REQ-021 Latency: an item written at edge N is presented on cl_item_valid_o/cl_item_data_o of the selected client from cycle N+1.
REQ-022 Only the selected client sees cl_item_valid_o = FIFO non-empty; all other clients see valid = 0 and data = 0.
REQ-023 The FIFO head is popped when the selected client's valid and cl_item_avail_i are both high.
REQ-024 The FSM has two states, IDLE and LOCKED, and resets to IDLE.
REQ-025 In IDLE with no cl_lock_i bit set, the head item is routed by command decode:
- command in [CMD_LO, CMD_HI] inclusive: the item goes to client 0 (owner_o = 0);
- any other command: the item is popped and discarded in one cycle, and drop_count_o increments, saturating at 16'hFFFF.
REQ-026 IDLE -> LOCKED occurs at the edge where any cl_lock_i bit is high; owner_o becomes the lowest set index.
- The new routing applies from the next cycle.
- Command decode and dropping are disabled while LOCKED.
REQ-027 In LOCKED, every item goes to the owner. LOCKED -> IDLE occurs at the edge where cl_lock_i[owner_o] is low; lock bits of other clients are ignored while LOCKED.
REQ-028 conflict_o is set to 1 in any cycle with more than one cl_lock_i bit high, and holds until reset.
REQ-029 Return path: item_data_o/item_valid_o come from the selected client.
- cl_item_avail_o[owner_o] follows the host-availability rule of REQ-033; every other bit of cl_item_avail_o is 0.
- Responses from unselected clients are ignored.
REQ-030 Simultaneous FIFO push and pop when not full keeps the count unchanged; read and write pointers wrap modulo IN_FIFO_DEPTH.

Reset
REQ-031 While reset is high, independent of clk:
- FIFO is emptied;
- FSM is in IDLE with owner_o = 0;
- locked_o = 0, conflict_o = 0, drop_count_o = 0;
- item_valid_o = 0, all cl_item_valid_o = 0, item_avail_o = 0.
REQ-032 On the first edge after reset falls, item_avail_o = 1. Any partial transaction in progress at reset is lost.

Configuration
REQ-033 Macro HOST_IF_OUT_REG_EN controls the return path.
- Defined: the return path passes through a one-entry output register, adding one cycle of latency. cl_item_avail_o[owner] = !reg_valid || item_avail_i. The register keeps its data while item_avail_i is low.
- Undefined: the return path is a combinational mux with zero latency, and cl_item_avail_o[owner] = item_avail_i.

Verification
REQ-034 Reset, then push commands 3, 5 and 20 with all clients available -> client 0 receives 3 then 5; 20 is dropped; drop_count_o = 1; owner_o = 0.
REQ-035 Hold cl_item_avail_i = 0 and push 5 items with IN_FIFO_DEPTH = 4 -> item_avail_o goes low after the 4th accepted item and the 5th is held by the host; releasing availability drains the items in order.
REQ-036 Assert cl_lock_i = 2'b10 and push commands 40 and 41 -> client 1 receives both; locked_o = 1; nothing is dropped; after cl_lock_i falls, state is IDLE on the next edge.
REQ-037 Assert cl_lock_i = 2'b11 in one cycle -> owner_o = 0 and conflict_o = 1; conflict_o stays 1 after the locks drop, until reset.
REQ-038 With client 1 owning the channel, client 1 sends 0xCAFE while item_avail_i = 0 for 2 cycles:
- macro defined: item_data_o = 0xCAFE appears one cycle after the send and is held for the 2 cycles;
- macro undefined: it appears in the same cycle;
- in both cases client 0's response is ignored.
REQ-039 Assert reset mid-stream with 3 items queued -> all outputs take their reset values immediately; no stale item appears after reset is released.
